// File: rtl/axil_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Response codes, write/read FSM state encodings, byte-strobe merge.
// Functions here are pure combinational helpers sized for DW <= 32.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rstate_t;

  // Replace byte b of old with byte b of wdata wherever wstrb[b] is set.
  // Callers narrower than 32 bits zero-extend and keep the low DW bits.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_wr_collect.sv
// Collects AW and W beats independently and fires wr_go when both are present.
// Latency: wr_go is combinational on the edge the later channel handshakes.
// Backpressure: each ready drops once its channel is held or while busy/not enabled.
module axil_wr_collect
  import axil_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            busy,
  input  logic [AW-1:0]   awaddr,
  input  logic            awvalid,
  output logic            awready,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic            wr_go,
  output logic [AW-1:0]   go_addr,
  output logic [DW-1:0]   go_data,
  output logic [DW/8-1:0] go_strb
);

  logic            aw_held_q, aw_held_d;
  logic            w_held_q, w_held_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   data_q, data_d;
  logic [DW/8-1:0] strb_q, strb_d;
  logic            aw_fire, w_fire;

  // Capture each channel on its own handshake; release both once the write is issued.
  always_comb begin
    awready   = en && !busy && !aw_held_q;
    wready    = en && !busy && !w_held_q;
    aw_fire   = awvalid && awready;
    w_fire    = wvalid && wready;
    wr_go     = (aw_held_q || aw_fire) && (w_held_q || w_fire);
    go_addr   = aw_held_q ? addr_q : awaddr;
    go_data   = w_held_q ? data_q : wdata;
    go_strb   = w_held_q ? strb_q : wstrb;
    aw_held_d = wr_go ? 1'b0 : (aw_held_q || aw_fire);
    w_held_d  = wr_go ? 1'b0 : (w_held_q || w_fire);
    addr_d    = aw_fire ? awaddr : addr_q;
    data_d    = w_fire ? wdata : data_q;
    strb_d    = w_fire ? wstrb : strb_q;
  end

  // Hold flags and buffers; reset discards any half-collected write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

endmodule

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: NREG x DW registers, per-register RO mask, SLVERR when out of range.
// Latency: B valid the cycle after the later of AW/W; R valid the cycle after AR.
// Backpressure: one outstanding write and one outstanding read; ready low until B/R accepted.
module axil_regbank
  import axil_pkg::*;
#(
  parameter int                 NREG      = 4,
  parameter int                 DW        = 32,
  parameter int                 AW        = 32,
  parameter int                 BYTE_ADDR = 0,
  parameter logic [NREG-1:0]    RO_MASK   = '0,
  parameter logic [NREG*DW-1:0] RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      cbus_awaddr,
  input  logic [2:0]         cbus_awprot,
  input  logic               cbus_awvalid,
  output logic               cbus_awready,
  input  logic [DW-1:0]      cbus_wdata,
  input  logic [DW/8-1:0]    cbus_wstrb,
  input  logic               cbus_wvalid,
  output logic               cbus_wready,
  output logic [1:0]         cbus_bresp,
  output logic               cbus_bvalid,
  input  logic               cbus_bready,
  input  logic [AW-1:0]      cbus_araddr,
  input  logic [2:0]         cbus_arprot,
  input  logic               cbus_arvalid,
  output logic               cbus_arready,
  output logic [DW-1:0]      cbus_rdata,
  output logic [1:0]         cbus_rresp,
  output logic               cbus_rvalid,
  input  logic               cbus_rready,
  output logic [NREG*DW-1:0] reg_q,
  input  logic [NREG*DW-1:0] reg_hw,
  output logic [NREG-1:0]    reg_wr
);

  localparam int SH = $clog2(DW / 8);

  logic            up_q;
  wstate_t         wstate_q, wstate_d;
  rstate_t         rstate_q, rstate_d;
  logic            bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  resp_t           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] reg_wr_q, reg_wr_d;
  logic            wr_go, ar_fire;
  logic [AW-1:0]   go_addr, widx, ridx;
  logic [DW-1:0]   go_data;
  logic [DW/8-1:0] go_strb;
  logic [31:0]     merged;
  logic            unused_prot;

  assign unused_prot = ^{cbus_awprot, cbus_arprot};

  axil_wr_collect #(.AW(AW), .DW(DW)) u_collect (
    .clk     (clk),
    .rst     (rst),
    .en      (up_q),
    .busy    (wstate_q == W_RESP),
    .awaddr  (cbus_awaddr),
    .awvalid (cbus_awvalid),
    .awready (cbus_awready),
    .wdata   (cbus_wdata),
    .wstrb   (cbus_wstrb),
    .wvalid  (cbus_wvalid),
    .wready  (cbus_wready),
    .wr_go   (wr_go),
    .go_addr (go_addr),
    .go_data (go_data),
    .go_strb (go_strb)
  );

  // Full-width index so high address bits never alias onto a real register.
  always_comb begin
    widx    = (BYTE_ADDR != 0) ? (go_addr >> SH) : go_addr;
    ridx    = (BYTE_ADDR != 0) ? (cbus_araddr >> SH) : cbus_araddr;
    ar_fire = cbus_arvalid && cbus_arready;
  end

  // Write side: apply the collected write, then hold B until accepted.
  always_comb begin
    wstate_d = wstate_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    reg_wr_d = '0;
    merged   = '0;
    case (wstate_q)
      W_IDLE: begin
        if (wr_go) begin
          wstate_d = W_RESP;
          bvalid_d = 1'b1;
          bresp_d  = SLVERR;
          for (int i = 0; i < NREG; i++) begin
            if (widx == AW'(i)) begin
              bresp_d = OKAY;
              if (!RO_MASK[i]) begin
                merged      = strb_merge(32'(regs_q[i]), 32'(go_data), 4'(go_strb));
                regs_d[i]   = merged[DW-1:0];
                reg_wr_d[i] = 1'b1;
              end
            end
          end
        end
      end
      W_RESP: begin
        if (cbus_bready) begin
          wstate_d = W_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read side: snapshot data at the AR edge, hold R until accepted.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    case (rstate_q)
      R_IDLE: begin
        if (ar_fire) begin
          rstate_d = R_RESP;
          rvalid_d = 1'b1;
          rresp_d  = SLVERR;
          rdata_d  = '0;
          for (int i = 0; i < NREG; i++) begin
            if (ridx == AW'(i)) begin
              rresp_d = OKAY;
              rdata_d = RO_MASK[i] ? reg_hw[i*DW +: DW] : regs_q[i];
            end
          end
        end
      end
      R_RESP: begin
        if (cbus_rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  // State, registers and registered response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q     <= 1'b0;
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      bresp_q  <= OKAY;
      rresp_q  <= OKAY;
      rdata_q  <= '0;
      reg_wr_q <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= RESET_VAL[i*DW +: DW];
    end else begin
      up_q     <= 1'b1;
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      bresp_q  <= bresp_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      reg_wr_q <= reg_wr_d;
      regs_q   <= regs_d;
    end
  end

  // Output wiring; AR is only taken once out of reset and with no read pending.
  always_comb begin
    cbus_arready = up_q && (rstate_q == R_IDLE);
    cbus_bvalid  = bvalid_q;
    cbus_bresp   = bresp_q;
    cbus_rvalid  = rvalid_q;
    cbus_rresp   = rresp_q;
    cbus_rdata   = rdata_q;
    reg_wr       = reg_wr_q;
    reg_q        = '0;
    for (int i = 0; i < NREG; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

endmodule
